// File: rtl/xoodyak_cmd_sequencer.sv
// xoodyak_cmd_sequencer
// Command stage in front of xoodyak_build. Host commands {opmode, data} are
// queued in a small FIFO and driven to the core one at a time. Each command is
// held until the core reports finished. One idle cycle follows before the next
// command is driven.
// Optional feature: define XOODYAK_SEQ_TIMEOUT_EN to enable a WAIT-state
// watchdog that abandons a command after TIMEOUT cycles without finished.
module xoodyak_cmd_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int MIN_HOLD   = 3,
    parameter int TIMEOUT    = 64,
    parameter int DATA_W     = 352
) (
    input  logic                        eph1,
    input  logic                        reset,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [4:0]                  cmd_opmode,
    input  logic [DATA_W-1:0]           cmd_data,
    output logic [4:0]                  core_opmode,
    output logic [DATA_W-1:0]           core_data,
    input  logic                        core_finished,
    output logic                        op_done,
    output logic                        op_timeout,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int HW = (MIN_HOLD > 1) ? $clog2(MIN_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MIN_HOLD - 1);
`ifdef XOODYAK_SEQ_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_GAP
    } state_t;

    logic [4:0]        op_mem   [FIFO_DEPTH];
    logic [DATA_W-1:0] data_mem [FIFO_DEPTH];

    logic [AW:0]       wr_ptr_q, rd_ptr_q;
    logic              head_vis_q;
    logic              full, empty, push, pop;
    logic [AW-1:0]     rd_idx;

    state_t            state_q, state_d;
    logic [HW-1:0]     hold_cnt_q, hold_cnt_d;
    logic              fin_seen_q, fin_seen_d;
    logic [4:0]        opmode_q, opmode_d;
    logic [DATA_W-1:0] data_q, data_d;
`ifdef XOODYAK_SEQ_TIMEOUT_EN
    logic [TW-1:0]     wait_cnt_q, wait_cnt_d;
`endif

    // Pointers carry a wrap bit so full and empty are distinguishable
    assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign cmd_ready  = !full;
    assign push       = cmd_valid && !full;
    assign pop        = (state_q == S_IDLE) && head_vis_q && !empty;
    assign rd_idx     = rd_ptr_q[AW-1:0];
    assign fifo_count = wr_ptr_q - rd_ptr_q;
    assign busy       = (state_q != S_IDLE) || !empty;

    assign core_opmode = opmode_q;
    assign core_data   = data_q;

    // FIFO storage; contents need no reset because the pointers guard them
    always_ff @(posedge eph1) begin
        if (push) begin
            op_mem[wr_ptr_q[AW-1:0]]   <= cmd_opmode;
            data_mem[wr_ptr_q[AW-1:0]] <= cmd_data;
        end
    end

    // FIFO pointers and the registered non-empty flag; the flag delays a fresh entry by one cycle so nothing bypasses the queue
    always_ff @(posedge eph1 or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            head_vis_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            head_vis_q <= !empty;
        end
    end

    // FSM state and registered core outputs
    always_ff @(posedge eph1 or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            hold_cnt_q <= '0;
            fin_seen_q <= 1'b0;
            opmode_q   <= '0;
            data_q     <= '0;
`ifdef XOODYAK_SEQ_TIMEOUT_EN
            wait_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            fin_seen_q <= fin_seen_d;
            opmode_q   <= opmode_d;
            data_q     <= data_d;
`ifdef XOODYAK_SEQ_TIMEOUT_EN
            wait_cnt_q <= wait_cnt_d;
`endif
        end
    end

    // Next-state logic: issue, minimum hold, wait for finished, then one idle gap cycle
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        fin_seen_d = fin_seen_q;
        opmode_d   = opmode_q;
        data_d     = data_q;
        op_done    = 1'b0;
        op_timeout = 1'b0;
`ifdef XOODYAK_SEQ_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                opmode_d = '0;
                data_d   = '0;
                if (pop) begin
                    opmode_d   = op_mem[rd_idx];
                    data_d     = data_mem[rd_idx];
                    hold_cnt_d = '0;
                    fin_seen_d = 1'b0;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (core_finished) fin_seen_d = 1'b1;
                if (hold_cnt_q == HOLD_LAST) begin
                    if ((opmode_q[3:0] == 4'd0) || fin_seen_q || core_finished) begin
                        op_done  = 1'b1;
                        opmode_d = '0;
                        data_d   = '0;
                        state_d  = S_GAP;
                    end else begin
                        state_d = S_WAIT;
`ifdef XOODYAK_SEQ_TIMEOUT_EN
                        wait_cnt_d = '0;
`endif
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end
            S_WAIT: begin
                if (core_finished) begin
                    op_done  = 1'b1;
                    opmode_d = '0;
                    data_d   = '0;
                    state_d  = S_GAP;
                end
`ifdef XOODYAK_SEQ_TIMEOUT_EN
                else if (wait_cnt_q == TIMEOUT_LAST) begin
                    op_timeout = 1'b1;
                    opmode_d   = '0;
                    data_d     = '0;
                    state_d    = S_GAP;
                end else begin
                    wait_cnt_d = wait_cnt_q + TW'(1);
                end
`endif
            end
            S_GAP: begin
                opmode_d   = '0;
                data_d     = '0;
                fin_seen_d = 1'b0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_xoodyak_cmd_sequencer.sv
// Self-checking bench for xoodyak_cmd_sequencer: per-cycle vector table for
// single-command sequences plus hand-written multi-cycle sequences for
// back-pressure, ordering, hold, watchdog and mid-operation reset.
module tb_xoodyak_cmd_sequencer;
    localparam int DW = 352;

    logic          eph1 = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [4:0]    cmd_opmode;
    logic [DW-1:0] cmd_data;
    logic [4:0]    core_opmode;
    logic [DW-1:0] core_data;
    logic          core_finished;
    logic          op_done;
    logic          op_timeout;
    logic          busy;
    logic [2:0]    fifo_count;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic          v;
        logic [4:0]    op;
        logic [DW-1:0] d;
        logic          fin;
        logic [4:0]    expOp;
        logic [DW-1:0] expData;
        logic          expDone;
        logic          expReady;
        logic [2:0]    expCount;
        logic          expBusy;
    } vec_t;

    vec_t vecs[18];
    int   nVec = 0;

    xoodyak_cmd_sequencer #(
        .FIFO_DEPTH(4),
        .MIN_HOLD(3),
        .TIMEOUT(16),
        .DATA_W(DW)
    ) dut (
        .eph1(eph1),
        .reset(reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_opmode(cmd_opmode),
        .cmd_data(cmd_data),
        .core_opmode(core_opmode),
        .core_data(core_data),
        .core_finished(core_finished),
        .op_done(op_done),
        .op_timeout(op_timeout),
        .busy(busy),
        .fifo_count(fifo_count)
    );

    always #5 eph1 = ~eph1;

    function automatic logic [DW-1:0] mkData(input int k);
        return {11{32'hC0DE_0000 | 32'(k)}};
    endfunction

    task automatic addVec(input logic v, input logic [4:0] op, input logic [DW-1:0] d, input logic fin,
                          input logic [4:0] eOp, input logic [DW-1:0] eData, input logic eDone,
                          input logic eRdy, input logic [2:0] eCnt, input logic eBusy);
        vecs[nVec] = '{v, op, d, fin, eOp, eData, eDone, eRdy, eCnt, eBusy};
        nVec++;
    endtask

    task automatic checkOutput(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
        end
    endtask

    // One table row per cycle: drive at the falling edge, compare 1 time unit later
    task automatic applyStimulus();
        for (int i = 0; i < nVec; i++) begin
            @(negedge eph1);
            cmd_valid     = vecs[i].v;
            cmd_opmode    = vecs[i].op;
            cmd_data      = vecs[i].d;
            core_finished = vecs[i].fin;
            #1;
            checkOutput($sformatf("vec%0d_opmode", i), DW'(core_opmode), DW'(vecs[i].expOp));
            checkOutput($sformatf("vec%0d_data", i), core_data, vecs[i].expData);
            checkOutput($sformatf("vec%0d_done", i), DW'(op_done), DW'(vecs[i].expDone));
            checkOutput($sformatf("vec%0d_ready", i), DW'(cmd_ready), DW'(vecs[i].expReady));
            checkOutput($sformatf("vec%0d_count", i), DW'(fifo_count), DW'(vecs[i].expCount));
            checkOutput($sformatf("vec%0d_busy", i), DW'(busy), DW'(vecs[i].expBusy));
        end
        cmd_valid     = 1'b0;
        core_finished = 1'b0;
    endtask

    task automatic pushCmd(input logic [4:0] op, input logic [DW-1:0] d, output bit ok);
        @(negedge eph1);
        cmd_valid  = 1'b1;
        cmd_opmode = op;
        cmd_data   = d;
        #1;
        ok = cmd_ready;
        @(posedge eph1);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic waitIssue(input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge eph1);
            #1;
            if (core_opmode != 5'd0) found = 1'b1;
        end
    endtask

    // Finished pulse in the first hold cycle: op_done must wait for the end of the hold, then a gap cycle
    task automatic serveNext(input string name, input logic [4:0] op, input logic [DW-1:0] d);
        bit found;
        waitIssue(30, found);
        checkOutput({name, "_issued"}, DW'(found), DW'(1));
        if (found) begin
            checkOutput({name, "_opmode"}, DW'(core_opmode), DW'(op));
            checkOutput({name, "_data"}, core_data, d);
            core_finished = 1'b1;
            #1;
            checkOutput({name, "_done_h0"}, DW'(op_done), DW'(0));
            @(negedge eph1);
            core_finished = 1'b0;
            #1;
            checkOutput({name, "_done_h1"}, DW'(op_done), DW'(0));
            @(negedge eph1);
            #1;
            checkOutput({name, "_done_h2"}, DW'(op_done), DW'(1));
            @(negedge eph1);
            #1;
            checkOutput({name, "_gap"}, DW'(core_opmode), DW'(0));
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not end, got running, want finished");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        logic [DW-1:0] key;
        logic [DW-1:0] pay;
        logic [4:0]    ops [6];
        bit            ok;
        bit            bad;
        bit            found;

        key = {128'h38393a3b3c3d3e3f3031323334353637, 224'h0};
        pay = {11{32'hA5A5_0F0F}};
        ops = '{5'h01, 5'h12, 5'h03, 5'h14, 5'h05, 5'h16};

        // Single key-init command finished in the 5th cycle after issue
        addVec(1, 5'h01, key, 0, 5'h00, '0, 0, 1, 0, 0);
        addVec(0, 5'h00, '0, 0, 5'h00, '0, 0, 1, 1, 1);
        addVec(0, 5'h00, '0, 0, 5'h00, '0, 0, 1, 1, 1);
        addVec(0, 5'h00, '0, 0, 5'h01, key, 0, 1, 0, 1);
        addVec(0, 5'h00, '0, 0, 5'h01, key, 0, 1, 0, 1);
        addVec(0, 5'h00, '0, 0, 5'h01, key, 0, 1, 0, 1);
        addVec(0, 5'h00, '0, 0, 5'h01, key, 0, 1, 0, 1);
        addVec(0, 5'h00, '0, 1, 5'h01, key, 1, 1, 0, 1);
        addVec(0, 5'h00, '0, 0, 5'h00, '0, 0, 1, 0, 1);
        addVec(0, 5'h00, '0, 0, 5'h00, '0, 0, 1, 0, 0);
        // Idle opmode: held MIN_HOLD cycles, completes without finished
        addVec(1, 5'h00, pay, 0, 5'h00, '0, 0, 1, 0, 0);
        addVec(0, 5'h00, '0, 0, 5'h00, '0, 0, 1, 1, 1);
        addVec(0, 5'h00, '0, 0, 5'h00, '0, 0, 1, 1, 1);
        addVec(0, 5'h00, '0, 0, 5'h00, pay, 0, 1, 0, 1);
        addVec(0, 5'h00, '0, 0, 5'h00, pay, 0, 1, 0, 1);
        addVec(0, 5'h00, '0, 0, 5'h00, pay, 1, 1, 0, 1);
        addVec(0, 5'h00, '0, 0, 5'h00, '0, 0, 1, 0, 1);
        addVec(0, 5'h00, '0, 0, 5'h00, '0, 0, 1, 0, 0);

        reset         = 1'b0;
        cmd_valid     = 1'b0;
        cmd_opmode    = '0;
        cmd_data      = '0;
        core_finished = 1'b0;
        #3;
        checkOutput("rst_opmode", DW'(core_opmode), DW'(0));
        checkOutput("rst_data", core_data, '0);
        checkOutput("rst_ready", DW'(cmd_ready), DW'(1));
        checkOutput("rst_count", DW'(fifo_count), DW'(0));
        checkOutput("rst_busy", DW'(busy), DW'(0));
        checkOutput("rst_done", DW'(op_done), DW'(0));
        checkOutput("rst_timeout", DW'(op_timeout), DW'(0));
        @(negedge eph1);
        reset = 1'b1;

        applyStimulus();

        // Back-pressure: A issued, B..E fill the FIFO, F waits for a free slot
        for (int k = 0; k < 5; k++) begin
            pushCmd(ops[k], mkData(k), ok);
            checkOutput($sformatf("bp_push%0d", k), DW'(ok), DW'(1));
        end
        cmd_valid  = 1'b1;
        cmd_opmode = ops[5];
        cmd_data   = mkData(5);
        @(negedge eph1);
        #1;
        checkOutput("bp_full_ready", DW'(cmd_ready), DW'(0));
        checkOutput("bp_full_count", DW'(fifo_count), DW'(4));
        checkOutput("bp_a_opmode", DW'(core_opmode), DW'(ops[0]));
        @(negedge eph1);
        #1;
        checkOutput("bp_a_wait_done", DW'(op_done), DW'(0));
        @(negedge eph1);
        core_finished = 1'b1;
        #1;
        checkOutput("bp_a_done", DW'(op_done), DW'(1));
        @(negedge eph1);
        core_finished = 1'b0;
        #1;
        checkOutput("bp_gap_opmode", DW'(core_opmode), DW'(0));
        checkOutput("bp_gap_ready", DW'(cmd_ready), DW'(0));
        @(negedge eph1);
        #1;
        checkOutput("bp_idle_ready", DW'(cmd_ready), DW'(0));
        @(negedge eph1);
        core_finished = 1'b1;
        #1;
        checkOutput("bp_freed_ready", DW'(cmd_ready), DW'(1));
        checkOutput("bp_b_opmode", DW'(core_opmode), DW'(ops[1]));
        checkOutput("bp_b_data", core_data, mkData(1));
        @(negedge eph1);
        cmd_valid     = 1'b0;
        core_finished = 1'b0;
        #1;
        checkOutput("bp_f_count", DW'(fifo_count), DW'(4));
        checkOutput("bp_b_done_h1", DW'(op_done), DW'(0));
        @(negedge eph1);
        #1;
        checkOutput("bp_b_done_h2", DW'(op_done), DW'(1));
        for (int k = 2; k < 6; k++) serveNext($sformatf("order%0d", k), ops[k], mkData(k));

        // Watchdog: G never finishes; H is queued behind it
        pushCmd(5'h04, mkData(20), ok);
        checkOutput("wd_push_g", DW'(ok), DW'(1));
        pushCmd(5'h07, mkData(21), ok);
        checkOutput("wd_push_h", DW'(ok), DW'(1));
        waitIssue(10, found);
        checkOutput("wd_g_issued", DW'(found), DW'(1));
        bad = 1'b0;
`ifdef XOODYAK_SEQ_TIMEOUT_EN
        for (int idx = 0; idx < 19; idx++) begin
            if (idx > 0) begin
                @(negedge eph1);
                #1;
            end
            if (op_done !== 1'b0 || core_opmode !== 5'h04) bad = 1'b1;
            if (op_timeout !== (idx == 18)) bad = 1'b1;
        end
        checkOutput("wd_timeout_at_16", DW'(bad), DW'(0));
        @(negedge eph1);
        #1;
        checkOutput("wd_gap_opmode", DW'(core_opmode), DW'(0));
        checkOutput("wd_gap_timeout", DW'(op_timeout), DW'(0));
`else
        for (int idx = 0; idx < 40; idx++) begin
            @(negedge eph1);
            #1;
            if (op_done !== 1'b0 || op_timeout !== 1'b0 || core_opmode !== 5'h04) bad = 1'b1;
        end
        checkOutput("wd_stays_wait", DW'(bad), DW'(0));
        @(negedge eph1);
        core_finished = 1'b1;
        #1;
        checkOutput("wd_late_done", DW'(op_done), DW'(1));
        @(negedge eph1);
        core_finished = 1'b0;
`endif
        serveNext("wd_next", 5'h07, mkData(21));

        // Reset while J waits and K, L, M are queued
        for (int k = 0; k < 4; k++) begin
            pushCmd(5'h02 + 5'(k), mkData(30 + k), ok);
            checkOutput($sformatf("mr_push%0d", k), DW'(ok), DW'(1));
        end
        @(negedge eph1);
        @(negedge eph1);
        @(negedge eph1);
        #1;
        checkOutput("mr_j_wait", DW'(core_opmode), DW'(5'h02));
        checkOutput("mr_queued", DW'(fifo_count), DW'(3));
        #1;
        reset = 1'b0;
        #1;
        checkOutput("mr_opmode", DW'(core_opmode), DW'(0));
        checkOutput("mr_data", core_data, '0);
        checkOutput("mr_count", DW'(fifo_count), DW'(0));
        checkOutput("mr_ready", DW'(cmd_ready), DW'(1));
        checkOutput("mr_busy", DW'(busy), DW'(0));
        checkOutput("mr_done", DW'(op_done), DW'(0));
        @(negedge eph1);
        reset = 1'b1;
        bad   = 1'b0;
        for (int idx = 0; idx < 6; idx++) begin
            @(negedge eph1);
            #1;
            if (op_done !== 1'b0 || busy !== 1'b0 || fifo_count !== 3'd0 || core_opmode !== 5'd0) bad = 1'b1;
        end
        checkOutput("mr_after_quiet", DW'(bad), DW'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
